// File: rtl/serial_cmp_pkg.sv
// Shared types and the digit-level magnitude compare for the framed serial comparator.
// Latency: none. The function is purely combinational.
// Backpressure: not applicable, because the package holds no state.
package serial_cmp_pkg;

    // Verdict of one unsigned digit compare.
    typedef enum logic [1:0] {
        CMP_LT,
        CMP_EQ,
        CMP_GT
    } cmp_res_t;

    // Widest digit the compare function accepts. Narrower digits are zero-extended by the caller.
    localparam int CMP_MAX_W = 64;

    function automatic cmp_res_t cmp_digit(input logic [CMP_MAX_W-1:0] a,
                                           input logic [CMP_MAX_W-1:0] b);
        cmp_res_t r;
        if (a < b) begin
            r = CMP_LT;
        end else if (a == b) begin
            r = CMP_EQ;
        end else begin
            r = CMP_GT;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_comparator_framed_step.sv
// Combinational step of the serial compare. It folds one digit pair into the running eq/gt flags.
// Latency: 0 cycles, because the block is purely combinational.
// Backpressure: none. The caller decides when a digit is consumed.
// Ports: a/b digit pair; msb_first/signed_mode effective mode for this word;
//        msb_digit marks the digit carrying the word's sign bit;
//        prev_eq/prev_gt in -> next_eq/next_gt out.
module serial_cmp_digit_step
    import serial_cmp_pkg::*;
#(
    parameter int DIGIT_W = 1
) (
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               msb_first,
    input  logic               signed_mode,
    input  logic               msb_digit,
    input  logic               prev_eq,
    input  logic               prev_gt,
    output logic               next_eq,
    output logic               next_gt
);

    logic [DIGIT_W-1:0] da;
    logic [DIGIT_W-1:0] db;
    cmp_res_t           d_res;

    always_comb begin
        da = a;
        db = b;
        // Flipping the sign bit maps two's-complement order onto unsigned order.
        if (signed_mode && msb_digit) begin
            da[DIGIT_W-1] = ~a[DIGIT_W-1];
            db[DIGIT_W-1] = ~b[DIGIT_W-1];
        end
        d_res = cmp_digit(CMP_MAX_W'(da), CMP_MAX_W'(db));

        next_eq = prev_eq;
        next_gt = prev_gt;
        if (msb_first) begin
            // The first differing digit from the top decides. Later digits cannot change it.
            if (prev_eq) begin
                next_eq = (d_res == CMP_EQ);
                next_gt = (d_res == CMP_GT);
            end
        end else begin
            // The last differing digit seen (the most significant one) overrides earlier ones.
            if (d_res != CMP_EQ) begin
                next_eq = 1'b0;
                next_gt = (d_res == CMP_GT);
            end
        end
    end

endmodule

// File: rtl/serial_comparator_framed.sv
// Word-framed serial magnitude comparator. It gives one lt/eq/gt verdict per WORD_LEN accepted digits.
// Latency: res_valid pulses 1 cycle after the last digit of a word is accepted.
// Backpressure: none. Every in_valid cycle is consumed, and in_valid low holds all state.
// Ports: clk/rst (sync, active-high); in_valid, a, b digit stream; msb_first/signed_mode
//        sampled on a word's first digit; restart aborts a partial word;
//        busy, res_valid, res_lt/res_eq/res_gt outputs.
module serial_comparator_framed
    import serial_cmp_pkg::*;
#(
    parameter int DIGIT_W  = 1,
    parameter int WORD_LEN = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               msb_first,
    input  logic               signed_mode,
    input  logic               restart,
    output logic               busy,
    output logic               res_valid,
    output logic               res_lt,
    output logic               res_eq,
    output logic               res_gt
);

    localparam int               CNT_W = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WORD_LEN - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_eff;
    logic             msb_q;
    logic             sgn_q;
    logic             run_eq;
    logic             run_gt;
    logic             first;
    logic             last;
    logic             msb_eff;
    logic             sgn_eff;
    logic             msb_digit;
    logic             prev_eq;
    logic             prev_gt;
    logic             next_eq;
    logic             next_gt;

    always_comb begin
        // A restart makes this cycle's digit, if any, the first digit of a fresh word.
        cnt_eff   = restart ? '0 : cnt;
        first     = (cnt_eff == '0);
        last      = (cnt_eff == LAST);
        msb_eff   = first ? msb_first   : msb_q;
        sgn_eff   = first ? signed_mode : sgn_q;
        msb_digit = msb_eff ? first : last;
        prev_eq   = first ? 1'b1 : run_eq;
        prev_gt   = first ? 1'b0 : run_gt;
    end

    serial_cmp_digit_step #(
        .DIGIT_W(DIGIT_W)
    ) u_step (
        .a           (a),
        .b           (b),
        .msb_first   (msb_eff),
        .signed_mode (sgn_eff),
        .msb_digit   (msb_digit),
        .prev_eq     (prev_eq),
        .prev_gt     (prev_gt),
        .next_eq     (next_eq),
        .next_gt     (next_gt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            msb_q     <= 1'b0;
            sgn_q     <= 1'b0;
            run_eq    <= 1'b1;
            run_gt    <= 1'b0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            res_eq    <= 1'b1;
            res_gt    <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            if (in_valid) begin
                if (first) begin
                    msb_q <= msb_first;
                    sgn_q <= signed_mode;
                end
                if (last) begin
                    res_eq    <= next_eq;
                    res_gt    <= next_gt;
                    res_valid <= 1'b1;
                    cnt       <= '0;
                    busy      <= 1'b0;
                end else begin
                    cnt    <= cnt_eff + CNT_W'(1);
                    run_eq <= next_eq;
                    run_gt <= next_gt;
                    busy   <= 1'b1;
                end
            end else if (restart) begin
                cnt    <= '0;
                run_eq <= 1'b1;
                run_gt <= 1'b0;
                busy   <= 1'b0;
            end
        end
    end

    assign res_lt = ~res_eq & ~res_gt;

endmodule
